// File: rtl/approx_add_err_profiler_pkg.sv
// Shared types and width helpers for the approximate-adder error profiler.
package approx_add_err_profiler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Accumulator widths chosen so a full 2^(2W) sweep can never overflow.
    function automatic int sae_w(input int w);
        return 3 * w + 1;
    endfunction

    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sse_w(input int w);
        return 4 * w + 2;
    endfunction

endpackage

// File: rtl/approx_add_err_accum.sv
// Error accumulators (SAE, WCE, error count, optional SSE) with synchronous clear.
// Optional SSE accumulator enabled by APPROX_ADD_ERR_PROF_MSE_EN.
module approx_add_err_accum
    import approx_add_err_profiler_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  vld,
    input  logic [W:0]            err,
    output logic [sae_w(W)-1:0]   sae,
    output logic [W:0]            wce,
    output logic [cnt_w(W)-1:0]   err_cnt
`ifdef APPROX_ADD_ERR_PROF_MSE_EN
    ,
    output logic [sse_w(W)-1:0]   sse
`endif
);

    localparam int SAE_W = sae_w(W);
    localparam int CNT_W = cnt_w(W);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sae     <= '0;
            wce     <= '0;
            err_cnt <= '0;
        end else if (clr) begin
            sae     <= '0;
            wce     <= '0;
            err_cnt <= '0;
        end else if (vld) begin
            sae     <= sae + SAE_W'(err);
            err_cnt <= err_cnt + CNT_W'(err != '0);
            if (err > wce) begin
                wce <= err;
            end
        end
    end

`ifdef APPROX_ADD_ERR_PROF_MSE_EN
    localparam int SSE_W = sse_w(W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sse <= '0;
        end else if (clr) begin
            sse <= '0;
        end else if (vld) begin
            sse <= sse + SSE_W'(err) * SSE_W'(err);
        end
    end
`endif

endmodule

// File: rtl/approx_add_err_profiler.sv
// Exhaustive operand sweeper and error profiler for one approximate W-bit adder.
// Optional sum-of-squared-errors output enabled by APPROX_ADD_ERR_PROF_MSE_EN.
module approx_add_err_profiler
    import approx_add_err_profiler_pkg::*;
#(
    parameter int W       = 8,
    parameter int RES_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [W-1:0]          op_a,
    output logic [W-1:0]          op_b,
    input  logic [W:0]            dut_o,
    output logic [sae_w(W)-1:0]   sae,
    output logic [W:0]            wce,
    output logic [cnt_w(W)-1:0]   err_cnt
`ifdef APPROX_ADD_ERR_PROF_MSE_EN
    ,
    output logic [sse_w(W)-1:0]   sse
`endif
);

    localparam int IDX_W     = 2 * W;
    localparam int DRAIN_CYC = RES_LAT + 2;
    localparam int DRN_W     = $clog2(DRAIN_CYC + 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [DRN_W-1:0]   drain_cnt;
    logic               clr;
    logic               issue;
    logic               issue_vld;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                issue = 1'b1;
                if (idx == '1) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRN_W'(DRAIN_CYC - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            drain_cnt <= '0;
            op_a      <= '0;
            op_b      <= '0;
            issue_vld <= 1'b0;
        end else begin
            state     <= state_nxt;
            issue_vld <= issue;
            if (clr) begin
                idx <= '0;
            end else if (issue) begin
                idx          <= idx + IDX_W'(1);
                {op_b, op_a} <= idx;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + DRN_W'(1) : '0;
        end
    end

    // Exact reference travels alongside the DUT latency so both meet at capture.
    logic [W:0] exact;
    logic [W:0] lat_exact;
    logic       lat_vld;

    assign exact = {1'b0, op_a} + {1'b0, op_b};

    generate
        if (RES_LAT == 0) begin : g_no_delay
            assign lat_exact = exact;
            assign lat_vld   = issue_vld;
        end else begin : g_delay
            logic [W:0]         dl_sum [RES_LAT];
            logic [RES_LAT-1:0] dl_vld;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dl_vld <= '0;
                end else begin
                    dl_vld[0] <= issue_vld;
                    for (int i = 1; i < RES_LAT; i++) begin
                        dl_vld[i] <= dl_vld[i-1];
                    end
                end
            end

            // NOTE: the data stages carry no reset; the valid flag alone decides
            // whether a stage is meaningful, so resetting the payload buys nothing.
            always_ff @(posedge clk) begin
                dl_sum[0] <= exact;
                for (int i = 1; i < RES_LAT; i++) begin
                    dl_sum[i] <= dl_sum[i-1];
                end
            end

            assign lat_exact = dl_sum[RES_LAT-1];
            assign lat_vld   = dl_vld[RES_LAT-1];
        end
    endgenerate

    logic       cap_vld;
    logic [W:0] cap_dut;
    logic [W:0] cap_exact;
    logic [W:0] err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld <= 1'b0;
        end else begin
            cap_vld <= lat_vld;
        end
    end

    always_ff @(posedge clk) begin
        cap_dut   <= dut_o;
        cap_exact <= lat_exact;
    end

    assign err = (cap_dut >= cap_exact) ? (cap_dut - cap_exact) : (cap_exact - cap_dut);

    approx_add_err_accum #(
        .W (W)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .vld     (cap_vld),
        .err     (err),
        .sae     (sae),
        .wce     (wce),
        .err_cnt (err_cnt)
`ifdef APPROX_ADD_ERR_PROF_MSE_EN
        ,
        .sse     (sse)
`endif
    );

endmodule

// File: tb/tb_approx_add_err_profiler.sv
// Self-checking bench: three profiler instances (W=8 exact, W=4 zero-output, W=4 xor-1 with latency 2).
module tb_approx_add_err_profiler;

    typedef struct {
        longint sae;
        longint wce;
        longint cnt;
        longint sse;
        int     cycles;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] start_v;
    logic [2:0] busy_x;
    logic [2:0] done_x;

    logic [63:0] sae_x [3];
    logic [63:0] wce_x [3];
    logic [63:0] cnt_x [3];
    logic [63:0] sse_x [3];
    logic [63:0] op_x  [3];

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt [3];
    exp_t sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: W=8, combinational exact adder.
    logic [7:0]  a0, b0;
    logic [8:0]  d0, sae_w0;
    logic [8:0]  wce0;
    logic [24:0] sae0;
    logic [16:0] cnt0;
    assign d0 = {1'b0, a0} + {1'b0, b0};

    // Instance 1: W=4, DUT output stuck at zero.
    logic [3:0]  a1, b1;
    logic [4:0]  wce1;
    logic [12:0] sae1;
    logic [8:0]  cnt1;

    // Instance 2: W=4, (A+B)^1 delayed two cycles.
    logic [3:0]  a2, b2;
    logic [4:0]  wce2, d2_p0, d2_p1;
    logic [12:0] sae2;
    logic [8:0]  cnt2;
    always @(posedge clk) begin
        d2_p0 <= ({1'b0, a2} + {1'b0, b2}) ^ 5'd1;
        d2_p1 <= d2_p0;
    end

`ifdef APPROX_ADD_ERR_PROF_MSE_EN
    logic [33:0] sse0;
    logic [17:0] sse1, sse2;
`endif

    approx_add_err_profiler #(.W(8), .RES_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_x[0]), .done(done_x[0]),
        .op_a(a0), .op_b(b0), .dut_o(d0), .sae(sae0), .wce(wce0), .err_cnt(cnt0)
`ifdef APPROX_ADD_ERR_PROF_MSE_EN
        , .sse(sse0)
`endif
    );

    approx_add_err_profiler #(.W(4), .RES_LAT(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_x[1]), .done(done_x[1]),
        .op_a(a1), .op_b(b1), .dut_o(5'd0), .sae(sae1), .wce(wce1), .err_cnt(cnt1)
`ifdef APPROX_ADD_ERR_PROF_MSE_EN
        , .sse(sse1)
`endif
    );

    approx_add_err_profiler #(.W(4), .RES_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy_x[2]), .done(done_x[2]),
        .op_a(a2), .op_b(b2), .dut_o(d2_p1), .sae(sae2), .wce(wce2), .err_cnt(cnt2)
`ifdef APPROX_ADD_ERR_PROF_MSE_EN
        , .sse(sse2)
`endif
    );

    assign sae_w0 = '0;
    always_comb begin
        sae_x[0] = 64'(sae0); wce_x[0] = 64'(wce0); cnt_x[0] = 64'(cnt0); op_x[0] = 64'({b0, a0});
        sae_x[1] = 64'(sae1); wce_x[1] = 64'(wce1); cnt_x[1] = 64'(cnt1); op_x[1] = 64'({b1, a1});
        sae_x[2] = 64'(sae2); wce_x[2] = 64'(wce2); cnt_x[2] = 64'(cnt2); op_x[2] = 64'({b2, a2});
`ifdef APPROX_ADD_ERR_PROF_MSE_EN
        sse_x[0] = 64'(sse0); sse_x[1] = 64'(sse1); sse_x[2] = 64'(sse2);
`else
        sse_x[0] = 64'(sae_w0); sse_x[1] = '0; sse_x[2] = '0;
`endif
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_x[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference model: walks every operand pair independently of the RTL pipeline.
    function automatic exp_t model(input int sel);
        exp_t r;
        int w, lat;
        longint e, d, err;
        w   = (sel == 0) ? 8 : 4;
        lat = (sel == 2) ? 2 : 0;
        r.sae = 0; r.wce = 0; r.cnt = 0; r.sse = 0;
        for (int a = 0; a < (1 << w); a++) begin
            for (int b = 0; b < (1 << w); b++) begin
                e = longint'(a + b);
                d = (sel == 0) ? e : (sel == 1) ? 0 : (e ^ 1);
                err = (d >= e) ? d - e : e - d;
                r.sae += err;
                r.sse += err * err;
                if (err != 0) r.cnt++;
                if (err > r.wce) r.wce = err;
            end
        end
        r.cycles = (1 << (2 * w)) + lat + 3;
        return r;
    endfunction

    task automatic run_sweep(input int sel, input bit restart_mid, input string tag);
        exp_t ex;
        int cyc, limit, done_before;
        sb.push_back(model(sel));
        limit = sb[$].cycles + 20;
        done_before = done_cnt[sel];
        @(posedge clk); #1 start_v[sel] = 1'b1;
        @(posedge clk); #1 start_v[sel] = 1'b0;
        cyc = 1;
        check({tag, "_busy_after_start"}, 64'(busy_x[sel]), 64'd1);
        while (!done_x[sel] && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
            if (restart_mid && cyc == 40) start_v[sel] = 1'b1;
            if (restart_mid && cyc == 41) start_v[sel] = 1'b0;
        end
        ex = sb.pop_front();
        check({tag, "_done_cycles"}, 64'(cyc), 64'(ex.cycles));
        check({tag, "_sae"}, sae_x[sel], 64'(ex.sae));
        check({tag, "_wce"}, wce_x[sel], 64'(ex.wce));
        check({tag, "_err_cnt"}, cnt_x[sel], 64'(ex.cnt));
`ifdef APPROX_ADD_ERR_PROF_MSE_EN
        check({tag, "_sse"}, sse_x[sel], 64'(ex.sse));
`endif
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_pulses"}, 64'(done_cnt[sel] - done_before), 64'd1);
        check({tag, "_busy_idle"}, 64'(busy_x[sel]), 64'd0);
        check({tag, "_sae_hold"}, sae_x[sel], 64'(ex.sae));
    endtask

    initial begin
        int cyc, done_before;
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;
        rst_n   = 1'b0;
        start_v = '0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", 64'(busy_x[i]), 64'd0);
            check("rst_done", 64'(done_x[i]), 64'd0);
            check("rst_ops",  op_x[i], 64'd0);
            check("rst_sae",  sae_x[i], 64'd0);
        end
        #21 rst_n = 1'b1;

        run_sweep(0, 1'b0, "w8_exact");
        run_sweep(2, 1'b0, "w4_xor1_lat2");
        run_sweep(1, 1'b0, "w4_zero");
        run_sweep(1, 1'b1, "w4_zero_restart");

        // Asynchronous reset in the middle of a sweep.
        done_before = done_cnt[1];
        @(posedge clk); #1 start_v[1] = 1'b1;
        @(posedge clk); #1 start_v[1] = 1'b0;
        cyc = 0;
        while (op_x[1] != 64'd100 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("midrst_reach_idx100", op_x[1], 64'd100);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy_x[1]), 64'd0);
        check("midrst_done", 64'(done_x[1]), 64'd0);
        check("midrst_ops", op_x[1], 64'd0);
        check("midrst_sae", sae_x[1], 64'd0);
        check("midrst_wce", wce_x[1], 64'd0);
        check("midrst_err_cnt", cnt_x[1], 64'd0);
`ifdef APPROX_ADD_ERR_PROF_MSE_EN
        check("midrst_sse", sse_x[1], 64'd0);
`endif
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("midrst_no_done", 64'(done_cnt[1] - done_before), 64'd0);
        check("midrst_still_idle", 64'(busy_x[1]), 64'd0);

        run_sweep(1, 1'b0, "w4_zero_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
